// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register/data widths, the scoreboard slot
// record, and the helper that decides whether a slot produces a given index.
package pipe_pkg;

    localparam int RW = 5;
    localparam int DW = 32;

    typedef logic [RW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;

    // One in-flight register write: valid, destination index, load flag.
    typedef struct packed {
        logic     v;
        reg_idx_t rw;
        logic     load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{v: 1'b0, rw: '0, load: 1'b0};

    // Where a forwarded operand comes from, in priority order.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_RF
    } src_t;

    // A slot matches index r when it is live, targets r, and r is not r0.
    function automatic logic slot_match(input slot_t s, input reg_idx_t r);
        return s.v && (s.rw == r) && (r != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-stage operand bus: ID instruction fields, register file read data,
// producer results from EX/MEM/WB, and the ID/EX latch outputs.
interface operand_fetch_if;
    import pipe_pkg::*;

    // ID instruction
    logic     id_valid;
    reg_idx_t id_ra;
    reg_idx_t id_rb;
    logic     id_wr;
    reg_idx_t id_rw;
    logic     id_load;

    // Register file read ports
    data_t    rf_a;
    data_t    rf_b;

    // Producer values further down the pipe
    data_t    ex_result;
    logic     ex_overflow;
    data_t    mem_result;
    data_t    wb_data;

    // Branch redirect
    logic     flush;

    // Hazard and ID/EX latch outputs
    logic     stall;
    logic     ex_valid;
    data_t    ex_op_a;
    data_t    ex_op_b;

    // Pipeline side: drives the instruction and producer values.
    modport master (
        output id_valid, id_ra, id_rb, id_wr, id_rw, id_load,
        output rf_a, rf_b, ex_result, ex_overflow, mem_result, wb_data, flush,
        input  stall, ex_valid, ex_op_a, ex_op_b
    );

    // Operand fetch block.
    modport slave (
        input  id_valid, id_ra, id_rb, id_wr, id_rw, id_load,
        input  rf_a, rf_b, ex_result, ex_overflow, mem_result, wb_data, flush,
        output stall, ex_valid, ex_op_a, ex_op_b
    );

endinterface

// File: rtl/operand_fetch_fwd_sel.sv
// Per-operand forwarding mux: picks the youngest pending producer of idx,
// falling back to the register file. Purely combinational.
module fwd_sel
    import pipe_pkg::*;
(
    input  reg_idx_t idx,
    input  data_t    rf_data,
    input  slot_t    ex_slot,
    input  logic     ex_overflow,
    input  slot_t    mem_slot,
    input  slot_t    wb_slot,
    input  data_t    ex_result,
    input  data_t    mem_result,
    input  data_t    wb_data,
    output data_t    data
);

    src_t src;

    // Priority decode: r0, then EX (ALU results only, not overflowed), MEM, WB, RF.
    // A load sitting in EX has no data yet; the hazard unit stalls on it, so
    // falling through here only produces a value that is never latched.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // otherwise a missed branch infers a latch.
        src = SRC_RF;
        if (idx == '0) begin
            src = SRC_ZERO;
        end else if (slot_match(ex_slot, idx) && !ex_slot.load && !ex_overflow) begin
            src = SRC_EX;
        end else if (slot_match(mem_slot, idx)) begin
            src = SRC_MEM;
        end else if (slot_match(wb_slot, idx)) begin
            src = SRC_WB;
        end
    end

    // Data mux driven by the decoded source.
    always_comb begin
        data = rf_data;
        case (src)
            SRC_ZERO: data = '0;
            SRC_EX:   data = ex_result;
            SRC_MEM:  data = mem_result;
            SRC_WB:   data = wb_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand reader. Keeps a three-slot scoreboard of in-flight
// register writes (EX, MEM, WB), forwards operands from the youngest
// producer, raises a one-cycle load-use stall, and registers the selected
// operands into the ID/EX latch.
module operand_fetch
    import pipe_pkg::*;
(
    input logic            clk,
    input logic            rst,
    operand_fetch_if.slave bus
);

    slot_t ex_slot,  ex_slot_next;
    slot_t mem_slot, mem_slot_next;
    slot_t wb_slot,  wb_slot_next;

    logic  load_use;
    logic  issue;
    data_t sel_a;
    data_t sel_b;

    logic  ex_valid_q;
    data_t ex_op_a_q;
    data_t ex_op_b_q;

    // Operand A and B forwarding muxes.
    fwd_sel u_fwd_a (
        .idx         (bus.id_ra),
        .rf_data     (bus.rf_a),
        .ex_slot     (ex_slot),
        .ex_overflow (bus.ex_overflow),
        .mem_slot    (mem_slot),
        .wb_slot     (wb_slot),
        .ex_result   (bus.ex_result),
        .mem_result  (bus.mem_result),
        .wb_data     (bus.wb_data),
        .data        (sel_a)
    );

    fwd_sel u_fwd_b (
        .idx         (bus.id_rb),
        .rf_data     (bus.rf_b),
        .ex_slot     (ex_slot),
        .ex_overflow (bus.ex_overflow),
        .mem_slot    (mem_slot),
        .wb_slot     (wb_slot),
        .ex_result   (bus.ex_result),
        .mem_result  (bus.mem_result),
        .wb_data     (bus.wb_data),
        .data        (sel_b)
    );

    // Load-use hazard: a load in EX whose destination is read by a live ID
    // instruction. Depends only on indices and the EX slot, never on data.
    always_comb begin
        load_use = 1'b0;
        if (bus.id_valid && ex_slot.load) begin
            load_use = slot_match(ex_slot, bus.id_ra) || slot_match(ex_slot, bus.id_rb);
        end
    end

    // The ID instruction moves into EX this cycle; flush wins over stall.
    assign issue = bus.id_valid && !load_use && !bus.flush;

    // Scoreboard advance. A flushed or overflowed EX write never reaches MEM,
    // and a write to r0 is never tracked.
    always_comb begin
        wb_slot_next  = mem_slot;
        mem_slot_next = ex_slot;
        if (bus.ex_overflow || bus.flush) begin
            mem_slot_next.v = 1'b0;
        end
        ex_slot_next = SLOT_EMPTY;
        if (issue && bus.id_wr && (bus.id_rw != '0)) begin
            ex_slot_next = '{v: 1'b1, rw: bus.id_rw, load: bus.id_load};
        end
    end

    // Scoreboard registers; reset drops every pending write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
            wb_slot  <= SLOT_EMPTY;
        end else begin
            ex_slot  <= ex_slot_next;
            mem_slot <= mem_slot_next;
            wb_slot  <= wb_slot_next;
        end
    end

    // ID/EX latch: operands load only with a real instruction, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_a_q  <= '0;
            ex_op_b_q  <= '0;
        end else begin
            ex_valid_q <= issue;
            if (issue) begin
                ex_op_a_q <= sel_a;
                ex_op_b_q <= sel_b;
            end
        end
    end

    assign bus.stall    = load_use;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op_a  = ex_op_a_q;
    assign bus.ex_op_b  = ex_op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding from each stage, load-use
// stall, overflow suppression, r0, flush vs stall, and mid-run reset.
module tb_operand_fetch;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid    = 1'b0;
        bus.id_ra       = '0;
        bus.id_rb       = '0;
        bus.id_wr       = 1'b0;
        bus.id_rw       = '0;
        bus.id_load     = 1'b0;
        bus.rf_a        = '0;
        bus.rf_b        = '0;
        bus.ex_result   = '0;
        bus.ex_overflow = 1'b0;
        bus.mem_result  = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
    endtask

    // Three idle cycles empty every scoreboard slot.
    task automatic drain();
        clear_inputs();
        repeat (3) step();
    endtask

    // Present a writer of rw for one cycle.
    task automatic produce(input logic [4:0] rw, input logic ld);
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_wr    = 1'b1;
        bus.id_rw    = rw;
        bus.id_load  = ld;
        step();
    endtask

    initial begin
        // Reset state
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_op_a", bus.ex_op_a, 0);
        check("rst_op_b", bus.ex_op_b, 0);
        check("rst_stall", bus.stall, 0);

        // First instruction reads the register file
        bus.id_valid = 1'b1;
        bus.id_ra    = 5'd3;
        bus.rf_a     = 32'h11;
        #1;
        check("rf_stall", bus.stall, 0);
        step();
        check("rf_op_a", bus.ex_op_a, 32'h11);
        check("rf_ex_valid", bus.ex_valid, 1);

        // r5 forwarded from EX, then MEM, then WB, then gone
        drain();
        produce(5'd5, 1'b0);
        clear_inputs();
        bus.id_valid  = 1'b1;
        bus.id_ra     = 5'd5;
        bus.ex_result = 32'h1234;
        #1;
        check("ex_fwd_stall", bus.stall, 0);
        step();
        check("ex_fwd_op_a", bus.ex_op_a, 32'h1234);
        bus.ex_result  = 32'hDEAD;
        bus.mem_result = 32'h5678;
        step();
        check("mem_fwd_op_a", bus.ex_op_a, 32'h5678);
        bus.id_ra      = 5'd0;
        bus.id_rb      = 5'd5;
        bus.mem_result = 32'hDEAD;
        bus.wb_data    = 32'h9ABC;
        step();
        check("wb_fwd_op_b", bus.ex_op_b, 32'h9ABC);
        check("wb_fwd_op_a_r0", bus.ex_op_a, 0);
        bus.id_rb   = 5'd0;
        bus.id_ra   = 5'd5;
        bus.rf_a    = 32'h55;
        bus.wb_data = 32'hDEAD;
        step();
        check("retired_op_a", bus.ex_op_a, 32'h55);

        // EX and MEM both write r6: EX wins, then MEM beats WB
        drain();
        produce(5'd6, 1'b0);
        produce(5'd6, 1'b0);
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.id_ra      = 5'd6;
        bus.ex_result  = 32'hE0;
        bus.mem_result = 32'hE1;
        bus.wb_data    = 32'hE2;
        step();
        check("youngest_ex", bus.ex_op_a, 32'hE0);
        step();
        check("youngest_mem", bus.ex_op_a, 32'hE1);

        // Load-use on operand B: one stall cycle, then forward from MEM
        drain();
        produce(5'd8, 1'b1);
        clear_inputs();
        bus.id_rb = 5'd8;
        #1;
        check("lu_no_valid_stall", bus.stall, 0);
        bus.id_valid = 1'b1;
        #1;
        check("lu_stall", bus.stall, 1);
        step();
        check("lu_bubble_ex_valid", bus.ex_valid, 0);
        check("lu_stall_released", bus.stall, 0);
        bus.mem_result = 32'hCAFE;
        bus.ex_result  = 32'hBAD;
        step();
        check("lu_op_b", bus.ex_op_b, 32'hCAFE);
        check("lu_ex_valid", bus.ex_valid, 1);

        // Overflowed EX write of r9 is neither forwarded nor tracked
        drain();
        produce(5'd9, 1'b0);
        clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_ra       = 5'd9;
        bus.rf_a        = 32'h77;
        bus.ex_result   = 32'hBEEF;
        bus.ex_overflow = 1'b1;
        step();
        check("ovf_op_a", bus.ex_op_a, 32'h77);
        bus.ex_overflow = 1'b0;
        bus.mem_result  = 32'h1111;
        step();
        check("ovf_not_in_mem", bus.ex_op_a, 32'h77);
        bus.wb_data = 32'h2222;
        step();
        check("ovf_not_in_wb", bus.ex_op_a, 32'h77);

        // Write to r0 is never forwarded
        drain();
        produce(5'd0, 1'b0);
        clear_inputs();
        bus.id_valid  = 1'b1;
        bus.ex_result = 32'hFFFF;
        bus.rf_a      = 32'h1234;
        bus.rf_b      = 32'h4321;
        step();
        check("r0_op_a", bus.ex_op_a, 0);
        check("r0_op_b", bus.ex_op_b, 0);

        // Flush together with load-use stall kills both ID and EX writers
        drain();
        produce(5'd10, 1'b1);
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_rb    = 5'd10;
        bus.id_wr    = 1'b1;
        bus.id_rw    = 5'd11;
        bus.flush    = 1'b1;
        #1;
        check("flush_stall_raised", bus.stall, 1);
        step();
        check("flush_ex_valid", bus.ex_valid, 0);
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.id_ra      = 5'd11;
        bus.id_rb      = 5'd10;
        bus.rf_a       = 32'hCD;
        bus.rf_b       = 32'hAB;
        bus.ex_result  = 32'hEEE;
        bus.mem_result = 32'h999;
        bus.wb_data    = 32'h888;
        #1;
        check("flush_no_stall", bus.stall, 0);
        step();
        check("flush_killed_id_wr", bus.ex_op_a, 32'hCD);
        check("flush_killed_ex_wr", bus.ex_op_b, 32'hAB);
        check("post_flush_valid", bus.ex_valid, 1);

        // Reset with three valid slots drops them all
        drain();
        produce(5'd12, 1'b0);
        produce(5'd13, 1'b0);
        produce(5'd14, 1'b0);
        bus.id_rw = 5'd15;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ex_valid", bus.ex_valid, 0);
        check("mid_rst_op_a", bus.ex_op_a, 0);
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.id_ra      = 5'd12;
        bus.id_rb      = 5'd14;
        bus.rf_a       = 32'h12;
        bus.rf_b       = 32'h14;
        bus.ex_result  = 32'hE;
        bus.mem_result = 32'hA;
        bus.wb_data    = 32'hB;
        step();
        check("rst_drop_wb", bus.ex_op_a, 32'h12);
        check("rst_drop_ex", bus.ex_op_b, 32'h14);
        bus.id_ra = 5'd13;
        bus.id_rb = 5'd15;
        bus.rf_a  = 32'h13;
        bus.rf_b  = 32'h15;
        step();
        check("rst_drop_mem", bus.ex_op_a, 32'h13);
        check("rst_blocks_load", bus.ex_op_b, 32'h15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
